// File: rtl/pe_row_mac.sv
// Convolution-row processing element: a TAPS-deep sliding ifmap window is
// multiplied against a TAPS-deep weight shift register.  Each full window
// produces one saturated signed partial sum, optionally accumulated onto
// the previous one.  Two pipeline stages: products, then sum/accumulate.
module pe_row_mac #(
  parameter int IFMAP_W  = 8,
  parameter int WEIGHT_W = 8,
  parameter int TAPS     = 3,
  parameter int PSUM_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [WEIGHT_W-1:0] weight,
  input  logic                weight_wen,
  output logic                w_loaded,
  input  logic [IFMAP_W-1:0]  ifmap,
  input  logic                acc_first,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [PSUM_W-1:0]   psum,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int PROD_W = IFMAP_W + WEIGHT_W;
  localparam int CNT_W  = $clog2(TAPS + 1);
  // sum of TAPS products never needs more than PROD_W + clog2(TAPS+1) bits
  localparam int SUMP_W = PROD_W + CNT_W;
  // one extra bit above the wider operand so base + sum cannot wrap
  localparam int ACC_W  = ((PSUM_W > SUMP_W) ? PSUM_W : SUMP_W) + 1;
  localparam logic [CNT_W-1:0] TAPS_CNT = CNT_W'(TAPS);
  localparam logic signed [ACC_W-1:0] PSUM_MAX =
    signed'((ACC_W'(1) << (PSUM_W - 1)) - ACC_W'(1));
  localparam logic signed [ACC_W-1:0] PSUM_MIN = ~PSUM_MAX;

  logic signed [WEIGHT_W-1:0] w_reg     [TAPS];
  logic signed [WEIGHT_W-1:0] w_next    [TAPS];
  logic signed [IFMAP_W-1:0]  win_reg   [TAPS];
  logic signed [IFMAP_W-1:0]  win_next  [TAPS];
  logic signed [PROD_W-1:0]   prod_next [TAPS];
  logic signed [PROD_W-1:0]   prod_reg  [TAPS];
  logic [CNT_W-1:0]           w_cnt_reg;
  logic [CNT_W-1:0]           fill_reg;
  logic                       s1_v_reg;
  logic                       s1_first_reg;
  logic signed [PSUM_W-1:0]   psum_reg;
  logic                       out_valid_reg;

  logic                       stall;
  logic                       accept;
  logic                       window_done;
  logic                       s1_load;
  logic signed [ACC_W-1:0]    sum_c;
  logic signed [ACC_W-1:0]    base_c;
  logic signed [ACC_W-1:0]    total_c;
  logic signed [PSUM_W-1:0]   sat_c;

  assign stall       = out_valid_reg & ~out_ready;
  assign w_loaded    = (w_cnt_reg == TAPS_CNT);
  assign in_ready    = w_loaded & ~weight_wen & ~stall & ~clr;
  assign accept      = in_valid & in_ready;
  // this beat fills the window if TAPS-1 samples are already present
  assign window_done = (fill_reg >= TAPS_CNT - CNT_W'(1));
  assign s1_load     = accept & window_done;
  assign psum        = psum_reg;
  assign out_valid   = out_valid_reg;

  // Post-shift views of both shift registers and the per-tap products
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    if (gi == TAPS - 1) begin : g_head
      assign w_next[gi]   = weight;
      assign win_next[gi] = ifmap;
    end else begin : g_body
      assign w_next[gi]   = w_reg[gi+1];
      assign win_next[gi] = win_reg[gi+1];
    end
    assign prod_next[gi] = PROD_W'(w_reg[gi]) * PROD_W'(win_next[gi]);
  end

  // Weight shift register and load counter; untouched by clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) w_reg[k] <= '0;
      w_cnt_reg <= '0;
    end else if (weight_wen) begin
      for (int k = 0; k < TAPS; k++) w_reg[k] <= w_next[k];
      if (!w_loaded) w_cnt_reg <= w_cnt_reg + CNT_W'(1);
    end
  end

  // Ifmap window and fill count advance on every accepted beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) win_reg[k] <= '0;
      fill_reg <= '0;
    end else if (clr) begin
      for (int k = 0; k < TAPS; k++) win_reg[k] <= '0;
      fill_reg <= '0;
    end else if (accept) begin
      for (int k = 0; k < TAPS; k++) win_reg[k] <= win_next[k];
      if (fill_reg != TAPS_CNT) fill_reg <= fill_reg + CNT_W'(1);
    end
  end

  // Stage 1: capture products of a completed window; hold while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) prod_reg[k] <= '0;
      s1_v_reg     <= 1'b0;
      s1_first_reg <= 1'b0;
    end else if (clr) begin
      s1_v_reg <= 1'b0;
    end else if (!stall) begin
      s1_v_reg <= s1_load;
      if (s1_load) begin
        for (int k = 0; k < TAPS; k++) prod_reg[k] <= prod_next[k];
        s1_first_reg <= acc_first;
      end
    end
  end

  // Adder tree plus accumulate base, then clamp to the output width
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < TAPS; k++) sum_c = sum_c + ACC_W'(prod_reg[k]);
    base_c  = s1_first_reg ? '0 : ACC_W'(psum_reg);
    total_c = base_c + sum_c;
    if (total_c > PSUM_MAX)      sat_c = PSUM_MAX[PSUM_W-1:0];
    else if (total_c < PSUM_MIN) sat_c = PSUM_MIN[PSUM_W-1:0];
    else                         sat_c = total_c[PSUM_W-1:0];
  end

  // Stage 2: output register; psum holds its value once consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psum_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else if (clr) begin
      psum_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else if (s1_v_reg && !stall) begin
      psum_reg      <= sat_c;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule
